// File: rtl/rh_xfer_cnt_if.sv
// rh_xfer_cnt_if: register-decode / DMA-sequencer side signals of the
// multi-channel transfer counter. The master modport is the controller
// (decode + sequencer); the slave modport is the counter block itself.
interface rh_xfer_cnt_if #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 18
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  devRESET;
  logic [CHANNELS-1:0]   clr;
  logic [SELW-1:0]       sel;
  logic                  wc_write;
  logic [WIDTH/8-1:0]    byte_en;
  logic [WIDTH-1:0]      wdata;
  logic                  ba_write;
  logic [ADDR_WIDTH-1:0] ba_wdata;
  logic [CHANNELS-1:0]   inc;
  logic [SELW-1:0]       rd_sel;
  logic [WIDTH-1:0]      wc_out;
  logic [ADDR_WIDTH-1:0] ba_out;
  logic [CHANNELS-1:0]   active;
  logic [CHANNELS-1:0]   done;
  logic [CHANNELS-1:0]   tc_pulse;
  logic [CHANNELS-1:0]   overrun;

  modport master (
    output devRESET, clr, sel, wc_write, byte_en, wdata,
           ba_write, ba_wdata, inc, rd_sel,
    input  wc_out, ba_out, active, done, tc_pulse, overrun
  );

  modport slave (
    input  devRESET, clr, sel, wc_write, byte_en, wdata,
           ba_write, ba_wdata, inc, rd_sel,
    output wc_out, ba_out, active, done, tc_pulse, overrun
  );
endinterface

// File: rtl/rh_xfer_cnt.sv
// rh_xfer_cnt: multi-channel word-count / bus-address transfer counter for
// RH-class massbus/DMA controllers. Each channel holds a negative WC that
// counts up to zero and a BA that advances by ADDR_STEP per word.
// Per-channel state: IDLE -> ACTIVE (nonzero WC written) -> DONE (WC hits 0).
// Optional build macro RH_XFER_CNT_OVERRUN_EN adds a sticky per-channel flag
// set by an inc that arrives while the channel is not ACTIVE.
module rh_xfer_cnt #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 18,
  parameter int ADDR_STEP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  rh_xfer_cnt_if.slave bus
);
  localparam int SELW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NBYTES = WIDTH / 8;

  // Encoding chosen so active/done come straight off a state register bit.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam logic [WIDTH-1:0]      WC_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      WC_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      WC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] BA_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] BA_STEP = ADDR_WIDTH'(ADDR_STEP);

  logic [CHANNELS-1:0][WIDTH-1:0]      wcR, wcNxtS, wcMergeS;
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] baR, baNxtS;
  logic [CHANNELS-1:0][1:0]            stateR, stateNxtS;
  logic [CHANNELS-1:0]                 tcR, tcNxtS;
  logic [CHANNELS-1:0]                 clrHitS, wcWrHitS, baWrHitS;
  logic [CHANNELS-1:0]                 activeS, doneS;
  logic [WIDTH-1:0]                    wcOutS;
  logic [ADDR_WIDTH-1:0]               baOutS;

  // Byte-lane merge: enabled lanes take new data, the rest keep the old WC.
  function automatic logic [WIDTH-1:0] mergeBytes(
    input logic [WIDTH-1:0]  oldV,
    input logic [WIDTH-1:0]  newV,
    input logic [NBYTES-1:0] be
  );
    logic [WIDTH-1:0] res;
    res = oldV;
    for (int k = 0; k < NBYTES; k++) begin
      res[8*k +: 8] = be[k] ? newV[8*k +: 8] : oldV[8*k +: 8];
    end
    return res;
  endfunction

  // Decode clears, addressed writes and the byte-merged WC for every channel.
  always_comb begin
    clrHitS  = {CHANNELS{1'b0}};
    wcWrHitS = {CHANNELS{1'b0}};
    baWrHitS = {CHANNELS{1'b0}};
    wcMergeS = wcR;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      clrHitS[ch]  = bus.devRESET | bus.clr[ch];
      wcWrHitS[ch] = bus.wc_write & (bus.sel == SELW'(ch));
      baWrHitS[ch] = bus.ba_write & (bus.sel == SELW'(ch));
      wcMergeS[ch] = mergeBytes(wcR[ch], bus.wdata, bus.byte_en);
    end
  end

  // Per-channel next state: clear > register write > word-transfer inc.
  always_comb begin
    wcNxtS    = wcR;
    baNxtS    = baR;
    stateNxtS = stateR;
    tcNxtS    = {CHANNELS{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (clrHitS[ch]) begin
        wcNxtS[ch]    = WC_ZERO;
        baNxtS[ch]    = BA_ZERO;
        stateNxtS[ch] = ST_IDLE;
        tcNxtS[ch]    = 1'b0;
      end else if (wcWrHitS[ch] || baWrHitS[ch]) begin
        // A write swallows any inc in the same cycle; a WC write also
        // re-arms from DONE, judged on the post-merge value.
        if (wcWrHitS[ch]) begin
          wcNxtS[ch]    = wcMergeS[ch];
          stateNxtS[ch] = (wcMergeS[ch] != WC_ZERO) ? ST_ACTIVE : ST_IDLE;
        end else begin
          wcNxtS[ch]    = wcR[ch];
          stateNxtS[ch] = stateR[ch];
        end
        if (baWrHitS[ch]) begin
          baNxtS[ch] = bus.ba_wdata;
        end else begin
          baNxtS[ch] = baR[ch];
        end
        tcNxtS[ch] = 1'b0;
      end else if (bus.inc[ch]) begin
        case (stateR[ch])
          ST_ACTIVE: begin
            wcNxtS[ch] = wcR[ch] + WC_ONE;
            baNxtS[ch] = baR[ch] + BA_STEP;
            if (wcR[ch] == WC_ONES) begin
              stateNxtS[ch] = ST_DONE;
              tcNxtS[ch]    = 1'b1;
            end else begin
              stateNxtS[ch] = ST_ACTIVE;
              tcNxtS[ch]    = 1'b0;
            end
          end
          ST_IDLE, ST_DONE: begin
            wcNxtS[ch]    = wcR[ch];
            baNxtS[ch]    = baR[ch];
            stateNxtS[ch] = stateR[ch];
            tcNxtS[ch]    = 1'b0;
          end
          default: begin
            // Unreachable encoding: fall back to a safe idle channel.
            wcNxtS[ch]    = wcR[ch];
            baNxtS[ch]    = baR[ch];
            stateNxtS[ch] = ST_IDLE;
            tcNxtS[ch]    = 1'b0;
          end
        endcase
      end else begin
        wcNxtS[ch]    = wcR[ch];
        baNxtS[ch]    = baR[ch];
        stateNxtS[ch] = stateR[ch];
        tcNxtS[ch]    = 1'b0;
      end
    end
  end

  // Channel registers: WC, BA, state and the one-cycle terminal-count strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcR    <= {(CHANNELS*WIDTH){1'b0}};
      baR    <= {(CHANNELS*ADDR_WIDTH){1'b0}};
      stateR <= {CHANNELS{ST_IDLE}};
      tcR    <= {CHANNELS{1'b0}};
    end else begin
      wcR    <= wcNxtS;
      baR    <= baNxtS;
      stateR <= stateNxtS;
      tcR    <= tcNxtS;
    end
  end

  // Readback mux (AND-OR so an out-of-range rd_sel reads as zero) and flags.
  always_comb begin
    wcOutS  = WC_ZERO;
    baOutS  = BA_ZERO;
    activeS = {CHANNELS{1'b0}};
    doneS   = {CHANNELS{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      wcOutS      = wcOutS | (wcR[ch] & {WIDTH{bus.rd_sel == SELW'(ch)}});
      baOutS      = baOutS | (baR[ch] & {ADDR_WIDTH{bus.rd_sel == SELW'(ch)}});
      activeS[ch] = stateR[ch][0];
      doneS[ch]   = stateR[ch][1];
    end
  end

  assign bus.wc_out   = wcOutS;
  assign bus.ba_out   = baOutS;
  assign bus.active   = activeS;
  assign bus.done     = doneS;
  assign bus.tc_pulse = tcR;

`ifdef RH_XFER_CNT_OVERRUN_EN
  logic [CHANNELS-1:0] ovrR, ovrNxtS;

  // Overrun: an inc reaching a non-ACTIVE channel sets it; only clears drop it.
  always_comb begin
    ovrNxtS = ovrR;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (clrHitS[ch]) begin
        ovrNxtS[ch] = 1'b0;
      end else if (!wcWrHitS[ch] && !baWrHitS[ch] && bus.inc[ch] &&
                   (stateR[ch] != ST_ACTIVE)) begin
        ovrNxtS[ch] = 1'b1;
      end else begin
        ovrNxtS[ch] = ovrR[ch];
      end
    end
  end

  // Sticky overrun flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovrR <= {CHANNELS{1'b0}};
    end else begin
      ovrR <= ovrNxtS;
    end
  end

  assign bus.overrun = ovrR;
`else
  assign bus.overrun = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_rh_xfer_cnt.sv
// tb_rh_xfer_cnt: directed vector table, hand sequences and randomized
// traffic for rh_xfer_cnt, all checked against a behavioural channel model.
module tb_rh_xfer_cnt;
  localparam int CH = 4;
`ifdef RH_XFER_CNT_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   nCmp = 0;
  int   nErr = 0;

  rh_xfer_cnt_if #(.CHANNELS(4), .WIDTH(16), .ADDR_WIDTH(18)) bus ();
  rh_xfer_cnt #(.CHANNELS(4), .WIDTH(16), .ADDR_WIDTH(18), .ADDR_STEP(2))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        dev;
    bit [3:0]  clr;
    bit [1:0]  sel;
    bit        wcw;
    bit [1:0]  be;
    bit [15:0] wd;
    bit        baw;
    bit [17:0] bwd;
    bit [3:0]  inc;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit [1:0]  chk;
    bit [15:0] wc;
    bit [17:0] ba;
    bit [3:0]  act;
    bit [3:0]  dn;
    bit [3:0]  tc;
    bit [3:0]  ov;
  } vec_t;

  // Reference model: plain integers and per-channel flags.
  int mWc [CH];
  int mBa [CH];
  bit mAct[CH];
  bit mDn [CH];
  bit mTc [CH];
  bit mOv [CH];

  function automatic stim_t S(bit dev, bit [3:0] clr, bit [1:0] sel, bit wcw,
                              bit [1:0] be, bit [15:0] wd, bit baw,
                              bit [17:0] bwd, bit [3:0] inc);
    stim_t s;
    s.dev = dev; s.clr = clr; s.sel = sel; s.wcw = wcw; s.be = be;
    s.wd = wd; s.baw = baw; s.bwd = bwd; s.inc = inc;
    return s;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < CH; c++) begin
      mWc[c] = 0; mBa[c] = 0; mAct[c] = 0; mDn[c] = 0; mTc[c] = 0; mOv[c] = 0;
    end
  endfunction

  function automatic void modelStep(stim_t s);
    for (int c = 0; c < CH; c++) begin
      bit wr;
      wr = (int'(s.sel) == c) && (s.wcw || s.baw);
      if (s.dev || s.clr[c]) begin
        mWc[c] = 0; mBa[c] = 0; mAct[c] = 0; mDn[c] = 0; mTc[c] = 0; mOv[c] = 0;
      end else if (wr) begin
        if (s.wcw) begin
          int v;
          v = mWc[c];
          for (int b = 0; b < 2; b++) begin
            if (s.be[b]) v = (v & ~(255 << (8 * b))) | (int'(s.wd) & (255 << (8 * b)));
          end
          mWc[c] = v;
          mAct[c] = (v != 0);
          mDn[c] = 0;
        end
        if (s.baw) mBa[c] = int'(s.bwd);
        mTc[c] = 0;
      end else if (s.inc[c]) begin
        if (mAct[c]) begin
          mWc[c] = (mWc[c] + 1) % 65536;
          mBa[c] = (mBa[c] + 2) % (1 << 18);
          mTc[c] = (mWc[c] == 0);
          if (mWc[c] == 0) begin
            mAct[c] = 0;
            mDn[c] = 1;
          end
        end else begin
          mTc[c] = 0;
          if (OVR_EN) mOv[c] = 1;
        end
      end else begin
        mTc[c] = 0;
      end
    end
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", nm, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.devRESET = 1'b0; bus.clr = 4'b0; bus.sel = 2'd0; bus.wc_write = 1'b0;
    bus.byte_en = 2'b0; bus.wdata = 16'h0; bus.ba_write = 1'b0;
    bus.ba_wdata = 18'h0; bus.inc = 4'b0;
  endtask

  // Compare every channel's readback plus the flag vectors against the model.
  task automatic checkAll();
    logic [3:0] eA, eD, eT, eO;
    for (int c = 0; c < CH; c++) begin
      bus.rd_sel = 2'(c);
      #1;
      cmp($sformatf("wc_out[ch%0d]", c), 32'(bus.wc_out), 32'(mWc[c]));
      cmp($sformatf("ba_out[ch%0d]", c), 32'(bus.ba_out), 32'(mBa[c]));
      eA[c] = mAct[c]; eD[c] = mDn[c]; eT[c] = mTc[c]; eO[c] = mOv[c];
    end
    cmp("active", 32'(bus.active), 32'(eA));
    cmp("done", 32'(bus.done), 32'(eD));
    cmp("tc_pulse", 32'(bus.tc_pulse), 32'(eT));
    cmp("overrun", 32'(bus.overrun), 32'(eO));
  endtask

  task automatic applyCycle(input stim_t s);
    bus.devRESET = s.dev; bus.clr = s.clr; bus.sel = s.sel; bus.wc_write = s.wcw;
    bus.byte_en = s.be; bus.wdata = s.wd; bus.ba_write = s.baw;
    bus.ba_wdata = s.bwd; bus.inc = s.inc;
    @(posedge clk);
    modelStep(s);
    #1;
    idleInputs();
    checkAll();
  endtask

  vec_t tbl[$];

  initial begin
    bit [3:0] ov2;
    stim_t    s;
    ov2 = OVR_EN ? 4'b0100 : 4'b0000;

    // Directed vectors: stimulus plus hand-derived expected readback/flags.
    tbl.push_back('{S(0,4'b0,2,0,2'b00,16'h0,1,18'o001000,4'b0), 2, 16'h0000, 18'o001000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,2,1,2'b11,16'hFFFD,0,18'h0,4'b0), 2, 16'hFFFD, 18'o001000, 4'b0100, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100), 2, 16'hFFFE, 18'o001002, 4'b0100, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100), 2, 16'hFFFF, 18'o001004, 4'b0100, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100), 2, 16'h0000, 18'o001006, 4'b0000, 4'b0100, 4'b0100, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0000), 2, 16'h0000, 18'o001006, 4'b0000, 4'b0100, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100), 2, 16'h0000, 18'o001006, 4'b0000, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,0,1,2'b11,16'h1234,0,18'h0,4'b0), 0, 16'h1234, 18'h0, 4'b0001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,0,1,2'b01,16'hABCD,0,18'h0,4'b0), 0, 16'h12CD, 18'h0, 4'b0001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,0,1,2'b10,16'h0000,0,18'h0,4'b0), 0, 16'h00CD, 18'h0, 4'b0001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,1,0,2'b00,16'h0,1,18'h155,4'b0), 1, 16'h0000, 18'h155, 4'b0001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,1,1,2'b11,16'hFFF0,0,18'h0,4'b0010), 1, 16'hFFF0, 18'h155, 4'b0011, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0010,1,1,2'b11,16'h1111,1,18'h3,4'b0010), 1, 16'h0000, 18'h0, 4'b0001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,3,1,2'b11,16'hFFFE,1,18'h3FFFE,4'b0), 3, 16'hFFFE, 18'h3FFFE, 4'b1001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,0,1,2'b11,16'hFFFF,0,18'h0,4'b0), 0, 16'hFFFF, 18'h0, 4'b1001, 4'b0100, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b1001), 3, 16'hFFFF, 18'h0, 4'b1000, 4'b0101, 4'b0001, ov2});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0000), 0, 16'h0000, 18'h2, 4'b1000, 4'b0101, 4'b0000, ov2});
    tbl.push_back('{S(0,4'b0,1,1,2'b11,16'hFFFF,0,18'h0,4'b0), 1, 16'hFFFF, 18'h0, 4'b1010, 4'b0101, 4'b0000, ov2});
    tbl.push_back('{S(1,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b1010), 1, 16'h0000, 18'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0000), 1, 16'h0000, 18'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000});

    // Power-on reset: outputs must be zero while and after rst is held.
    rst = 1'b1;
    idleInputs();
    bus.rd_sel = 2'd0;
    modelReset();
    #2;
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      applyCycle(tbl[i].s);
      bus.rd_sel = tbl[i].chk;
      #1;
      cmp($sformatf("vec%0d wc_out", i), 32'(bus.wc_out), 32'(tbl[i].wc));
      cmp($sformatf("vec%0d ba_out", i), 32'(bus.ba_out), 32'(tbl[i].ba));
      cmp($sformatf("vec%0d active", i), 32'(bus.active), 32'(tbl[i].act));
      cmp($sformatf("vec%0d done", i), 32'(bus.done), 32'(tbl[i].dn));
      cmp($sformatf("vec%0d tc_pulse", i), 32'(bus.tc_pulse), 32'(tbl[i].tc));
      cmp($sformatf("vec%0d overrun", i), 32'(bus.overrun), 32'(tbl[i].ov));
    end

    // DONE, overrun, BA write keeps DONE, WC=1 re-arm keeps overrun.
    applyCycle(S(0,4'b0,2,1,2'b11,16'hFFFF,0,18'h0,4'b0));
    applyCycle(S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100));
    cmp("seq tc2 after last inc", 32'(bus.tc_pulse[2]), 32'd1);
    applyCycle(S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100));
    cmp("seq tc2 single cycle", 32'(bus.tc_pulse[2]), 32'd0);
    cmp("seq overrun2 from DONE", 32'(bus.overrun[2]), 32'(OVR_EN));
    applyCycle(S(0,4'b0,2,0,2'b00,16'h0,1,18'h100,4'b0));
    cmp("seq ba write keeps DONE", 32'(bus.done[2]), 32'd1);
    applyCycle(S(0,4'b0,2,1,2'b11,16'h0001,0,18'h0,4'b0));
    cmp("seq WC=1 rearms", 32'(bus.active[2]), 32'd1);
    cmp("seq rearm keeps overrun", 32'(bus.overrun[2]), 32'(OVR_EN));
    applyCycle(S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0100));
    cmp("seq WC=1 inc no tc", 32'(bus.tc_pulse[2]), 32'd0);
    applyCycle(S(0,4'b0,2,1,2'b11,16'h0000,0,18'h0,4'b0));
    cmp("seq WC=0 write idles", 32'(bus.active[2] | bus.done[2]), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      s.dev = ($urandom_range(0, 39) == 0);
      s.clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
      s.sel = 2'($urandom);
      s.wcw = ($urandom_range(0, 4) == 0);
      s.be  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      case ($urandom_range(0, 3))
        0:       s.wd = 16'($urandom);
        1:       s.wd = 16'h0000;
        default: s.wd = 16'hFFF8 | 16'($urandom_range(0, 7));
      endcase
      s.baw = ($urandom_range(0, 5) == 0);
      s.bwd = ($urandom_range(0, 1) == 0) ? 18'($urandom) : (18'h3FFF8 | 18'($urandom_range(0, 7)));
      s.inc = 4'($urandom);
      applyCycle(s);
    end

    // Asynchronous reset in the middle of activity.
    applyCycle(S(0,4'b0,1,1,2'b11,16'hFFF0,1,18'h1234,4'b0));
    bus.inc = 4'b1111;
    @(posedge clk);
    modelStep(S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b1111));
    #3;
    rst = 1'b1;
    modelReset();
    idleInputs();
    checkAll();
    @(negedge clk);
    rst = 1'b0;
    applyCycle(S(0,4'b0,0,0,2'b00,16'h0,0,18'h0,4'b0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rh_xfer_cnt.md
Name: rh_xfer_cnt

Overview:
- Parametrised multi-channel transfer counter for RH-class massbus/DMA controllers.
- Each channel holds a two's-complement negative word count (WC) and a bus address (BA), with byte-lane register writes.
- On each DMA word transfer, WC counts up towards zero and BA advances; a terminal-count event ends the transfer.
- Sits between the bus-interface register decode and the DMA sequencer; one instance serves all drives or channels of a controller.

Parameters:
CHANNELS, 4, number of independent WC/BA channel pairs (1..8)
WIDTH, 16, WC width in bits; must be a multiple of 8
ADDR_WIDTH, 18, BA width in bits
ADDR_STEP, 2, BA increment per transferred word (1, 2 or 4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
devRESET  in  1  synchronous clear of all channels
clr  in  CHANNELS  synchronous per-channel clear
sel  in  $clog2(CHANNELS) (min 1)  channel addressed by wc_write/ba_write
wc_write  in  1  write WC of channel sel
byte_en  in  WIDTH/8  byte-lane enables for wc_write; bit k covers wdata[8k+7:8k]
wdata  in  WIDTH  WC write data
ba_write  in  1  write BA of channel sel
ba_wdata  in  ADDR_WIDTH  BA write data, full-width write
inc  in  CHANNELS  per-channel one-word-transferred strobe
rd_sel  in  $clog2(CHANNELS) (min 1)  readback channel select
wc_out  out  WIDTH  WC of channel rd_sel (combinational mux)
ba_out  out  ADDR_WIDTH  BA of channel rd_sel (combinational mux)
active  out  CHANNELS  channel is in the ACTIVE state
done  out  CHANNELS  channel is in the DONE state
tc_pulse  out  CHANNELS  one-cycle terminal-count strobe
overrun  out  CHANNELS  sticky overrun flag (see Optional Feature)

Behaviour:
- rst:
  - All WC and BA are 0.
  - All channels IDLE.
  - tc_pulse, overrun and all outputs are 0.
- Per-channel state machine: IDLE, ACTIVE, DONE.
- Priority per channel, evaluated each clock: devRESET|clr[ch] > write (wc_write or ba_write to ch) > inc[ch].
- Clear:
  - WC=0, BA=0, state IDLE, overrun=0.
  - A write or inc in the same cycle is dropped.
- WC write:
  - Only the enabled byte lanes update; other bytes hold.
  - Next state is evaluated on the post-write WC value: nonzero -> ACTIVE; zero -> IDLE.
  - A WC write from DONE re-arms the channel. overrun is not cleared.
- BA write:
  - Replaces BA; state is unchanged.
  - Simultaneous wc_write and ba_write to the same sel both take effect.
- Write and inc in the same cycle on the same channel: the write wins, the inc is lost, and WC/BA are not advanced.
- inc[ch] in ACTIVE:
  - WC <= WC+1 (mod 2^WIDTH).
  - BA <= BA+ADDR_STEP (mod 2^ADDR_WIDTH; wraps silently).
  - If WC was all-ones (the new WC is 0): state -> DONE and tc_pulse[ch]=1 for exactly the following cycle.
- inc[ch] in IDLE or DONE: WC and BA hold (see Optional Feature).
- Multiple channels may inc in the same cycle; they are fully independent.
- Latency:
  - Registered state and flags update on the clock edge after the stimulus.
  - wc_out/ba_out reflect the new value in that cycle with no extra delay.
- devRESET while ACTIVE aborts the transfer: no tc_pulse is generated.
- WC=1 written is treated as nonzero: ACTIVE, and 2^WIDTH-1 incs are needed to reach terminal count.

Optional Feature:
- Macro: RH_XFER_CNT_OVERRUN_EN.
- When defined:
  - inc[ch] while DONE or IDLE sets overrun[ch] (sticky) in the next cycle.
  - overrun is cleared only by rst, devRESET or clr[ch].
- When undefined:
  - Such incs are silently ignored.
  - The overrun outputs are tied to 0 and no flag registers are synthesised.

Test Plan:
- Reset/readback: assert rst mid-run, then release; read every rd_sel -> wc_out=0, ba_out=0, active=0, done=0, tc_pulse=0.
- Basic transfer on ch2:
  - Stimulus: ba_write 18'o001000, wc_write 16'hFFFD with both lanes enabled, then 3 incs.
  - Required: ba_out=18'o001006, wc_out=0, a single tc_pulse[2] after the 3rd inc, done[2]=1.
  - A 4th inc leaves the values unchanged and sets overrun[2]=1 only when the macro is defined.
- Byte lanes: on ch0 holding WC=16'h1234, wc_write 16'hABCD with byte_en=2'b01 -> WC=16'h12CD, active=1.
  - Then byte_en=2'b10 with data 16'h0000 -> WC=16'h00CD, still active.
- Priority:
  - wc_write 16'hFFF0 and inc in the same cycle on ch1 -> WC=16'hFFF0, BA unchanged.
  - clr[1] together with a write -> WC=0, IDLE.
- Wrap and parallel incs:
  - Stimulus: BA of ch3=2^18-2, WC of ch3=16'hFFFE, WC of ch0=16'hFFFF; inc ch0 and ch3 in the same cycle.
  - Required: ch0 goes DONE with tc_pulse[0]; ch3 BA=0, WC=16'hFFFF, still ACTIVE.
- Abort: devRESET during ch1 ACTIVE with WC=16'hFFFF and inc asserted -> no tc_pulse, all channels IDLE, overrun cleared.
